regfile_operand_fetch: RTL

//  Register-file read side of the RISC pipeline. Consumes the stage-3 writeback word (din) and its opcode/destination.

---
 rtl/regfile_operand_fetch.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: register-file read stage with write-first bypass.
// Define SCOREBOARD_EN to add the read-after-write busy scoreboard driving hazard.
module regfile_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic [OPC_W-1:0]  dec_opcode,
    input  logic              stall,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] rd_d3,
    input  logic [OPC_W-1:0]  opcode_d3,
    output logic [DATA_W-1:0] reg_rs1_d2,
    output logic [DATA_W-1:0] reg_rs2_d2,
    output logic              opd_valid_d2,
    output logic              hazard
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] rs1_q, rs1_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;
    logic              vld_q, vld_d;
    logic              we;

    // Write-type opcodes: 1, 2 and 4..20 (STORE=3, NOP=0 and codes above 20 never write)
    function automatic logic is_wr(input logic [OPC_W-1:0] op);
        return (op != '0) && (op != OPC_W'(3)) && (op <= OPC_W'(20));
    endfunction

    assign we = is_wr(opcode_d3);

    // Register file storage; index 0 is never written so it stays zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we && rd_d3 != '0) begin
            regs_q[rd_d3] <= din;
        end
    end

    // Next operand values: hold on stall, otherwise read with write-first bypass
    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        vld_d = vld_q;
        if (!stall) begin
            vld_d = dec_valid;
            rs1_d = (dec_rs1 == '0) ? '0 : (we && rd_d3 == dec_rs1) ? din : regs_q[dec_rs1];
            rs2_d = (dec_rs2 == '0) ? '0 : (we && rd_d3 == dec_rs2) ? din : regs_q[dec_rs2];
        end
    end

    // Stage-2 operand registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs1_q <= '0;
            rs2_q <= '0;
            vld_q <= 1'b0;
        end else begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            vld_q <= vld_d;
        end
    end

    assign reg_rs1_d2   = rs1_q;
    assign reg_rs2_d2   = rs2_q;
    assign opd_valid_d2 = vld_q;

`ifdef SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                set_busy;

    assign hazard   = dec_valid && ((dec_rs1 != '0 && busy_q[dec_rs1]) ||
                                    (dec_rs2 != '0 && busy_q[dec_rs2]));
    assign set_busy = dec_valid && !stall && !hazard && is_wr(dec_opcode) && dec_rd != '0;

    // Clear on writeback, then set for a newly issued producer so the newer one wins
    always_comb begin
        busy_d = busy_q;
        if (we) busy_d[rd_d3] = 1'b0;
        if (set_busy) busy_d[dec_rd] = 1'b1;
    end

    // Busy bitmap register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else busy_q <= busy_d;
    end
`else
    logic unused_dec;
    assign unused_dec = ^{dec_rd, dec_opcode};
    assign hazard     = 1'b0;
`endif
endmodule
